// File: rtl/aes_tiled_round_seq.sv
// Sequences one AES round (enc/dec, normal/final) over the tiled AES unit, key XOR done locally.
// Optional AES_TILED_ROUND_ZEROISE_EN clears scratch, key and response data after each round.
module aes_tiled_round_seq (
   input  logic         g_clk,
   input  logic         g_resetn,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic         req_dec,
   input  logic         req_final,
   input  logic [127:0] req_state,
   input  logic [127:0] req_rkey,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [127:0] rsp_state,
   output logic         t_valid,
   output logic         t_dec,
   output logic         t_op_sb,
   output logic         t_op_sbsr,
   output logic         t_op_mix,
   output logic         t_hi,
   output logic [31:0]  t_rs1,
   output logic [31:0]  t_rs2,
   input  logic         t_ready,
   input  logic [31:0]  t_rd
);

   // Handshakes: a transfer happens on a rising edge where valid && ready; the
   // sender holds valid and its payload stable until that edge.

   typedef enum logic [2:0] {ST_IDLE, ST_SBSR, ST_MIX, ST_KEY, ST_DONE} state_t;

   state_t            state_q;
   logic [1:0]        k_q;
   logic [3:0][31:0]  w_q;
   logic [3:0][31:0]  s_q;
   logic [3:0][31:0]  rkey_q;
   logic              dec_q;
   logic              fin_q;

   logic [1:0]        s_idx;
   logic [3:0][31:0]  s_next;
   logic [3:0][31:0]  w_key;

   assign t_op_sb = 1'b0;

   // MixColumns writes scratch in order S0,S2,S1,S3: the index is k with bits swapped.
   always_comb begin
      s_idx         = (state_q == ST_MIX) ? {k_q[0], k_q[1]} : k_q;
      s_next        = s_q;
      s_next[s_idx] = t_rd;
      w_key         = w_q ^ rkey_q;
   end

   function automatic logic [63:0] op_operands(logic mix, logic [1:0] k, logic [3:0][31:0] w);
      logic [1:0] a;
      logic [1:0] b;
      if (mix) begin
         a = {k[0], k[1]};
         b = a ^ 2'b10;
      end else begin
         a = k;
         b = k ^ 2'b01;
      end
      return {w[a], w[b]};
   endfunction

   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         state_q   <= ST_IDLE;
         k_q       <= 2'd0;
         w_q       <= '0;
         s_q       <= '0;
         rkey_q    <= '0;
         dec_q     <= 1'b0;
         fin_q     <= 1'b0;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_state <= '0;
         t_valid   <= 1'b0;
         t_dec     <= 1'b0;
         t_op_sbsr <= 1'b0;
         t_op_mix  <= 1'b0;
         t_hi      <= 1'b0;
         t_rs1     <= '0;
         t_rs2     <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req_valid) begin
                  w_q            <= req_state;
                  rkey_q         <= req_rkey;
                  dec_q          <= req_dec;
                  fin_q          <= req_final;
                  k_q            <= 2'd0;
                  req_ready      <= 1'b0;
                  t_valid        <= 1'b1;
                  t_dec          <= req_dec;
                  t_op_sbsr      <= 1'b1;
                  t_op_mix       <= 1'b0;
                  t_hi           <= 1'b0;
                  {t_rs1, t_rs2} <= op_operands(1'b0, 2'd0, req_state);
                  state_q        <= ST_SBSR;
               end
            end
            ST_SBSR, ST_MIX: begin
               if (t_ready) begin
                  s_q <= s_next;
                  if (k_q != 2'd3) begin
                     k_q            <= k_q + 2'd1;
                     {t_rs1, t_rs2} <= op_operands(state_q == ST_MIX, k_q + 2'd1, w_q);
                     t_hi           <= (state_q == ST_SBSR) && (k_q != 2'd0);
                  end else begin
                     w_q <= s_next;
                     k_q <= 2'd0;
                     if (state_q == ST_SBSR && !dec_q && !fin_q) begin
                        state_q        <= ST_MIX;
                        t_op_sbsr      <= 1'b0;
                        t_op_mix       <= 1'b1;
                        t_hi           <= 1'b0;
                        {t_rs1, t_rs2} <= op_operands(1'b1, 2'd0, s_next);
                     end else begin
                        t_valid   <= 1'b0;
                        t_op_sbsr <= 1'b0;
                        t_op_mix  <= 1'b0;
                        t_hi      <= 1'b0;
`ifdef AES_TILED_ROUND_ZEROISE_EN
                        t_rs1     <= '0;
                        t_rs2     <= '0;
`endif
                        if (state_q == ST_MIX && dec_q) begin
                           state_q   <= ST_DONE;
                           rsp_valid <= 1'b1;
                           rsp_state <= s_next;
                        end else begin
                           state_q <= ST_KEY;
                        end
                     end
                  end
               end
            end
            ST_KEY: begin
               w_q <= w_key;
               if (dec_q && !fin_q) begin
                  state_q        <= ST_MIX;
                  t_valid        <= 1'b1;
                  t_op_mix       <= 1'b1;
                  t_hi           <= 1'b0;
                  {t_rs1, t_rs2} <= op_operands(1'b1, 2'd0, w_key);
               end else begin
                  state_q   <= ST_DONE;
                  rsp_valid <= 1'b1;
                  rsp_state <= w_key;
               end
            end
            ST_DONE: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
                  state_q   <= ST_IDLE;
`ifdef AES_TILED_ROUND_ZEROISE_EN
                  s_q       <= '0;
                  rkey_q    <= '0;
                  rsp_state <= '0;
`endif
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_tiled_round_seq.sv
// Bench for aes_tiled_round_seq: behavioural tiled unit, FIPS-197 round reference and a response scoreboard.
module tb_aes_tiled_round_seq;

   logic         g_clk = 1'b0;
   logic         g_resetn = 1'b0;
   logic         req_valid = 1'b0;
   logic         req_ready;
   logic         req_dec = 1'b0;
   logic         req_final = 1'b0;
   logic [127:0] req_state = '0;
   logic [127:0] req_rkey = '0;
   logic         rsp_valid;
   logic         rsp_ready = 1'b0;
   logic [127:0] rsp_state;
   logic         t_valid;
   logic         t_dec;
   logic         t_op_sb;
   logic         t_op_sbsr;
   logic         t_op_mix;
   logic         t_hi;
   logic [31:0]  t_rs1;
   logic [31:0]  t_rs2;
   logic         t_ready = 1'b1;
   logic [31:0]  t_rd;

   aes_tiled_round_seq dut (
      .g_clk(g_clk), .g_resetn(g_resetn),
      .req_valid(req_valid), .req_ready(req_ready), .req_dec(req_dec), .req_final(req_final),
      .req_state(req_state), .req_rkey(req_rkey),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_state(rsp_state),
      .t_valid(t_valid), .t_dec(t_dec), .t_op_sb(t_op_sb), .t_op_sbsr(t_op_sbsr),
      .t_op_mix(t_op_mix), .t_hi(t_hi), .t_rs1(t_rs1), .t_rs2(t_rs2),
      .t_ready(t_ready), .t_rd(t_rd)
   );

   always #5 g_clk = ~g_clk;

   int n_checks = 0;
   int n_pass = 0;
   logic [127:0] exp_q[$];
   logic [7:0] sbox[256];
   logic [7:0] inv_sbox[256];

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // ---------------- reference arithmetic ----------------
   function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
         b = b >> 1;
      end
      return p;
   endfunction

   task automatic build_sbox();
      for (int x = 0; x < 256; x++) begin
         logic [7:0] v;
         logic [7:0] b;
         v = 8'h01;
         if (x == 0) v = 8'h00;
         else for (int e = 0; e < 254; e++) v = gmul(v, 8'(x));
         b = v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
         sbox[x] = b;
         inv_sbox[b] = 8'(x);
      end
   endtask

   // bit offset of state byte s[r][c] in the tiled 128-bit layout
   function automatic int bpos(int r, int c);
      return 32 * ((r / 2) * 2 + c / 2) + 8 * (((c % 2) == 0 ? 2 : 0) + (r % 2));
   endfunction

   function automatic logic [127:0] mixc(logic [127:0] a, logic inv);
      logic [7:0] cf[4];
      logic [127:0] n = a;
      if (inv) begin cf[0] = 8'h0e; cf[1] = 8'h0b; cf[2] = 8'h0d; cf[3] = 8'h09; end
      else     begin cf[0] = 8'h02; cf[1] = 8'h03; cf[2] = 8'h01; cf[3] = 8'h01; end
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) begin
            logic [7:0] acc = 8'h00;
            for (int j = 0; j < 4; j++) acc = acc ^ gmul(cf[(j - r + 4) % 4], a[bpos(j, c) +: 8]);
            n[bpos(r, c) +: 8] = acc;
         end
      return n;
   endfunction

   function automatic logic [127:0] ref_round(logic [127:0] st, logic [127:0] rk, logic dec, logic fin);
      logic [127:0] a = st;
      logic [127:0] n = '0;
      if (!dec) begin
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) n[bpos(r, c) +: 8] = sbox[a[bpos(r, (c + r) % 4) +: 8]];
         a = fin ? n : mixc(n, 1'b0);
         a = a ^ rk;
      end else begin
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) n[bpos(r, c) +: 8] = inv_sbox[a[bpos(r, (c + 4 - r) % 4) +: 8]];
         a = n ^ rk;
         if (!fin) a = mixc(a, 1'b1);
      end
      return a;
   endfunction

   function automatic logic [127:0] fips_to_tiled(logic [127:0] f);
      logic [127:0] t = '0;
      for (int n = 0; n < 16; n++) t[bpos(n % 4, n / 4) +: 8] = f[127 - 8 * n -: 8];
      return t;
   endfunction

   // behavioural tiled unit: one word of SubBytes+ShiftRows or MixColumns
   function automatic logic [31:0] tiled_fn(logic [31:0] rs1, logic [31:0] rs2, logic sbsr,
                                            logic mix, logic hi, logic dec);
      logic [31:0] o = '0;
      if (mix) begin
         for (int h = 0; h < 2; h++) begin
            logic [7:0] x0, x1, y0, y1;
            x0 = rs1[16 * h +: 8]; x1 = rs1[16 * h + 8 +: 8];
            y0 = rs2[16 * h +: 8]; y1 = rs2[16 * h + 8 +: 8];
            if (!dec) begin
               o[16 * h +: 8]     = gmul(2, x0) ^ gmul(3, x1) ^ y0 ^ y1;
               o[16 * h + 8 +: 8] = x0 ^ gmul(2, x1) ^ gmul(3, y0) ^ y1;
            end else begin
               o[16 * h +: 8]     = gmul(14, x0) ^ gmul(11, x1) ^ gmul(13, y0) ^ gmul(9, y1);
               o[16 * h + 8 +: 8] = gmul(9, x0) ^ gmul(14, x1) ^ gmul(11, y0) ^ gmul(13, y1);
            end
         end
      end else if (sbsr) begin
         case ({dec, hi})
            2'b00: o = {rs1[15:8], rs1[23:16], rs2[31:24], rs1[7:0]};
            2'b01: o = {rs2[15:8], rs2[23:16], rs1[31:24], rs2[7:0]};
            2'b10: o = {rs2[15:8], rs1[23:16], rs1[31:24], rs1[7:0]};
            default: o = {rs1[15:8], rs2[23:16], rs2[31:24], rs2[7:0]};
         endcase
         for (int i = 0; i < 4; i++) o[8 * i +: 8] = dec ? inv_sbox[o[8 * i +: 8]] : sbox[o[8 * i +: 8]];
      end
      return o;
   endfunction

   assign t_rd = tiled_fn(t_rs1, t_rs2, t_op_sbsr, t_op_mix, t_hi, t_dec);

   // ---------------- tiled responder: stalls and handshake log ----------------
   int stall_left = 0;
   int hs_cnt = 0;
   logic [2:0] hs_log[16];
   logic stalled_prev = 1'b0;
   logic [64:0] stall_snap;

   always @(negedge g_clk) begin
      if (!g_resetn) begin
         t_ready = 1'b1;
         stalled_prev = 1'b0;
      end else begin
         if (stalled_prev) begin
            check("stall_t_valid", 128'(t_valid), 128'd1);
            check("stall_operands", 128'({t_hi, t_rs1, t_rs2}), 128'(stall_snap));
         end
         if (t_valid && stall_left > 0) begin
            t_ready = 1'b0;
            stall_left--;
            stalled_prev = 1'b1;
            stall_snap = {t_hi, t_rs1, t_rs2};
         end else begin
            t_ready = 1'b1;
            stalled_prev = 1'b0;
            if (t_valid) begin
               if (hs_cnt < 16) hs_log[hs_cnt] = {t_op_mix, t_op_sbsr, t_hi};
               hs_cnt++;
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send_req(input logic [127:0] st, input logic [127:0] rk, input logic dec, input logic fin);
      int w = 0;
      @(negedge g_clk);
      exp_q.push_back(ref_round(st, rk, dec, fin));
      hs_cnt = 0;
      req_state = st; req_rkey = rk; req_dec = dec; req_final = fin; req_valid = 1'b1;
      while (!req_ready && w < 20) begin @(negedge g_clk); w++; end
      if (!req_ready) check("req_accept_timeout", 128'(req_ready), 128'd1);
      @(posedge g_clk);
      #1 req_valid = 1'b0;
   endtask

   task automatic get_rsp(input int exp_lat, input int hold, output logic [127:0] got);
      int cyc = 0;
      logic [127:0] held;
      logic [127:0] exp;
      got = '0;
      do begin @(negedge g_clk); cyc++; end while (!rsp_valid && cyc < 60);
      check("latency", 128'(cyc), 128'(exp_lat));
      if (!rsp_valid) begin
         if (exp_q.size() > 0) void'(exp_q.pop_front());
         return;
      end
      held = rsp_state;
      for (int i = 0; i < hold; i++) begin
         req_valid = 1'b1;
         req_state = {4{$urandom}};
         check("done_req_ready", 128'(req_ready), 128'd0);
         check("done_rsp_stable", rsp_state, held);
         check("done_rsp_valid", 128'(rsp_valid), 128'd1);
         @(negedge g_clk);
      end
      req_valid = 1'b0;
      exp = exp_q.pop_front();
      check("rsp_state", rsp_state, exp);
      got = rsp_state;
      rsp_ready = 1'b1;
      @(posedge g_clk);
      #1 rsp_ready = 1'b0;
      @(negedge g_clk);
      check("back_idle", 128'({req_ready, rsp_valid}), 128'b10);
   endtask

   // ---------------- main sequence ----------------
   logic [127:0] got;
   logic [127:0] fips_in;
   logic [127:0] fips_rk;
   logic [127:0] fips_out;
   logic [2:0] exp_ops[8];

   initial begin
      build_sbox();
      fips_in  = fips_to_tiled(128'h193de3be_a0f4e22b_9ac68d2a_e9f84808);
      fips_rk  = fips_to_tiled(128'ha0fafe17_88542cb1_23a33939_2a6c7605);
      fips_out = fips_to_tiled(128'ha49c7ff2_689f352b_6b5bea43_026a5049);
      exp_ops[0] = 3'b010; exp_ops[1] = 3'b010; exp_ops[2] = 3'b011; exp_ops[3] = 3'b011;
      exp_ops[4] = 3'b100; exp_ops[5] = 3'b100; exp_ops[6] = 3'b100; exp_ops[7] = 3'b100;

      repeat (3) @(negedge g_clk);
      check("reset_req_ready", 128'(req_ready), 128'd1);
      check("reset_valids", 128'({rsp_valid, t_valid, t_op_sb, t_op_sbsr, t_op_mix, t_hi}), 128'd0);
      check("reset_rsp_state", rsp_state, 128'd0);
      check("reset_operands", 128'({t_rs1, t_rs2}), 128'd0);
      g_resetn = 1'b1;

      // encrypt final on zero state
      send_req('0, '0, 1'b0, 1'b1);
      get_rsp(6, 0, got);
      check("enc_final_value", got, {16{8'h63}});
      check("enc_final_hs", 128'(hs_cnt), 128'd4);

      // encrypt non-final: op sequence and count
      send_req('0, {16{8'h01}}, 1'b0, 1'b0);
      get_rsp(10, 0, got);
      check("enc_value", got, {16{8'h62}});
      check("enc_hs", 128'(hs_cnt), 128'd8);
      for (int i = 0; i < 8; i++) check($sformatf("enc_op%0d", i), 128'(hs_log[i]), 128'(exp_ops[i]));

      // decrypt final
      send_req({16{8'h63}}, '0, 1'b1, 1'b1);
      get_rsp(6, 0, got);
      check("dec_final_value", got, 128'd0);

      // FIPS-197 Appendix B round 1
      send_req(fips_in, fips_rk, 1'b0, 1'b0);
      get_rsp(10, 0, got);
      check("fips_round1", got, fips_out);

      // random rounds of every type
      for (int i = 0; i < 6; i++) begin
         logic d, f;
         d = i[0];
         f = (i >= 4);
         send_req({4{$urandom}}, {4{$urandom}}, d, f);
         get_rsp(f ? 6 : 10, 0, got);
      end

      // tiled stall on the first op
      stall_left = 3;
      send_req(fips_in, fips_rk, 1'b0, 1'b0);
      get_rsp(13, 0, got);

      // consumer back-pressure in DONE
      send_req(fips_in, fips_rk, 1'b1, 1'b0);
      get_rsp(10, 5, got);

      // reset pulsed during MIX k=1
      send_req(fips_in, fips_rk, 1'b0, 1'b0);
      repeat (6) @(negedge g_clk);
      check("mid_mix_phase", 128'({t_valid, t_op_mix}), 128'b11);
      #2 g_resetn = 1'b0;
      #1;
      check("rst_t_valid", 128'(t_valid), 128'd0);
      check("rst_rsp_valid", 128'(rsp_valid), 128'd0);
      check("rst_req_ready", 128'(req_ready), 128'd1);
      exp_q.delete();
      @(negedge g_clk);
      g_resetn = 1'b1;
      send_req(fips_in, fips_rk, 1'b0, 1'b0);
      get_rsp(10, 0, got);
      check("post_reset_fips", got, fips_out);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/aes_tiled_round_seq.md
Name: aes_tiled_round_seq

Overview:
- Upstream sequencer for the tiled AES instruction unit `aes_tiled`. It performs one full AES round on a 128-bit state held in tiled layout.
- Round types: encrypt or decrypt, normal or final.
- It issues the required SubBytes/ShiftRows and MixColumns operations to the tiled unit over its valid/ready port, then does the round-key XOR locally.
- Used by the AES coprocessor controller in place of software issuing 8 tiled instructions per round.

Parameters:
- None. State width is fixed at 128 bits (4 tiled words W0..W3).

Ports:
- g_clk  in  1  clock
- g_resetn  in  1  asynchronous active-low reset
- req_valid  in  1  round request valid
- req_ready  out  1  sequencer idle, request accepted when req_valid&&req_ready
- req_dec  in  1  0 encrypt round, 1 decrypt round
- req_final  in  1  final round (MixColumns skipped)
- req_state  in  128  input state, tiled layout; Wi = bits [32i+31:32i]
- req_rkey  in  128  round key, same tiled layout
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_state  out  128  round output, tiled layout
- t_valid  out  1  tiled unit request valid
- t_dec  out  1  tiled unit decrypt select
- t_op_sb  out  1  tied 0
- t_op_sbsr  out  1  SubBytes+ShiftRows op
- t_op_mix  out  1  MixColumns op
- t_hi  out  1  high (rows 2-3) ShiftRows select
- t_rs1  out  32  tiled unit operand 1
- t_rs2  out  32  tiled unit operand 2
- t_ready  in  1  tiled unit result ready
- t_rd  in  32  tiled unit result

Behaviour:
- Tiled layout, with s[r][c] the FIPS-197 state byte at row r, column c:
  - W0 = {s[1][0],s[0][0],s[1][1],s[0][1]}, MSB first.
  - W1 = {s[1][2],s[0][2],s[1][3],s[0][3]}.
  - W2 and W3 are the same as W0 and W1 using rows 2 and 3.
- Reset values: req_ready=1, rsp_valid=0, rsp_state=0, t_valid=0, t_op_*=0, t_hi=0, t_rs1=t_rs2=0. Scratch and state registers are cleared.
- Reset asserted mid-operation: every register clears immediately and the FSM returns to IDLE. Any in-flight tiled op is abandoned.
- FSM states: IDLE, SBSR, MIX, KEY, DONE. A 2-bit op counter k is used in SBSR and MIX.
- IDLE:
  - req_ready=1.
  - On accept, latch state, rkey, dec and final, then go to SBSR with k=0.
- SBSR op k, with t_dec=latched dec:
  - k=0: rs1=W0, rs2=W1, lo, result to S0.
  - k=1: rs1=W1, rs2=W0, lo, result to S1.
  - k=2: rs1=W2, rs2=W3, hi, result to S2.
  - k=3: rs1=W3, rs2=W2, hi, result to S3.
  - Results go to scratch S0..S3. W is not overwritten until all 4 ops are done; then W <= S.
- MIX op k:
  - k=0: rs1=W0, rs2=W2, result to S0.
  - k=1: rs1=W2, rs2=W0, result to S2.
  - k=2: rs1=W1, rs2=W3, result to S1.
  - k=3: rs1=W3, rs2=W1, result to S3.
  - W <= S after k=3.
- KEY: one cycle, W <= W ^ rkey, computed locally with no tiled op.
- Transition order:
  - Encrypt: SBSR -> MIX -> KEY -> DONE.
  - Encrypt final: SBSR -> KEY -> DONE.
  - Decrypt: SBSR -> KEY -> MIX -> DONE.
  - Decrypt final: SBSR -> KEY -> DONE.
- Tiled handshake:
  - t_valid and all t_* operands are registered and stay stable while t_valid && !t_ready.
  - t_rd is captured on the cycle t_valid&&t_ready.
  - The next op's operands are presented the following cycle, with t_valid kept high between consecutive ops of the same phase.
  - t_valid=0 in IDLE, KEY and DONE.
- DONE:
  - rsp_valid=1 and rsp_state=W, held stable until rsp_ready.
  - On rsp_valid&&rsp_ready go to IDLE.
  - A new request cannot be accepted in the same cycle (req_ready=0 in DONE).
- Latency with t_ready tied high: accept at cycle 0.
  - Non-final: rsp_valid first asserted at cycle 10.
  - Final: rsp_valid at cycle 6.
  - Each tiled stall cycle adds 1 cycle.
- req_* inputs are ignored outside IDLE.

Optional Feature:
- Macro: AES_TILED_ROUND_ZEROISE_EN.
- Defined: scratch S0..S3, latched rkey and rsp_state are cleared to 0 on the cycle DONE->IDLE. t_rs1/t_rs2 are driven 0 whenever t_valid=0.
- Undefined: these registers keep their last values, with no functional difference on handshaked outputs.

Test Plan:
- Encrypt final: state=0, rkey=0, t_ready=1 -> 4 SBSR ops, rsp_state=128'h63636363_63636363_63636363_63636363 at cycle 6.
- Encrypt non-final: state=0, rkey=128'h01010101_..._01 -> rsp_state=128'h62626262_..._62 at cycle 10; exactly 8 tiled handshakes (4 sbsr, 4 mix, in the specified operand order).
- Decrypt final: state all 0x63, rkey=0 -> rsp_state=0. FIPS-197 Appendix B round 1 (enc, non-final), converted to tiled layout -> matches the round-1 output.
- t_ready held low 3 cycles on the first SBSR op -> t_valid, t_rs1, t_rs2, t_hi stable throughout; rsp_valid delayed to cycle 13.
- rsp_ready held low 5 cycles in DONE -> rsp_state stable, req_ready=0, new req_valid ignored until the response is taken.
- g_resetn pulsed low during MIX k=1 -> t_valid=0 and rsp_valid=0 immediately, req_ready=1. A new request afterwards completes correctly.
